// File: rtl/radiant_trig_header_builder.sv
// radiant_trig_header_builder
// Builds one 96-bit header record per trigger (live or dead) and hands the
// records, in trigger order, to the event builder over a valid/ready port.
// Live records wait in the queue until the overlord reports that the matching
// readout has finished. Any record queued behind a waiting live record also
// waits, so dead records never overtake the live record in front of them.
//
// Handshake: a record moves when hdr_valid_o && hdr_ready_i at a rising edge.
// While hdr_valid_o is high and hdr_ready_i is low, hdr_valid_o and hdr_dat_o
// hold their values. hdr_valid_o never depends on hdr_ready_i in the same
// cycle.
//
// Record layout:
//   [31:0]  event number
//   [63:32] sub-second cycle count
//   [79:64] trig_info
//   [94:80] PPS count, low 15 bits
//   [95]    dead flag

module radiant_trig_header_builder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        sys_clk_i,
    input  logic        rst_n_i,
    input  logic        pps_i,
    input  logic        trig_i,
    input  logic        deadtrig_i,
    input  logic [15:0] trig_info_i,
    input  logic        trig_done_i,
    output logic        hdr_valid_o,
    input  logic        hdr_ready_i,
    output logic [95:0] hdr_dat_o,
    output logic        hdr_full_o,
    output logic [15:0] drop_count_o,
    output logic        overflow_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CREDIT_MAX = (DEPTH_LOG2 + 1)'(DEPTH + 1);
    localparam logic [DEPTH_LOG2:0] SKIP_MAX   = '1;

    // ------------------------------------------------------------------
    // Time and event bookkeeping
    // ------------------------------------------------------------------
    logic [31:0] subsec;
    // Only the low 15 bits of the PPS count ever leave the block, so only
    // those bits are kept; they wrap exactly as the low bits of a wider
    // counter would.
    logic [14:0] pps_cnt;
    logic [31:0] evnum;

    // ------------------------------------------------------------------
    // Header storage
    // ------------------------------------------------------------------
    // count   : records held, including the one shown on the output register.
    //           This is the occupancy that decides full, so the output
    //           register is one of the 2^DEPTH_LOG2 slots.
    // pend    : records written but not yet moved to the output register.
    // rd_ptr  : slot of the oldest record not yet moved to the output.
    logic [95:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   pend;

    // ------------------------------------------------------------------
    // Readout accounting
    // ------------------------------------------------------------------
    // credit : completed readouts not yet matched to a presented live record.
    // skip   : dropped live triggers whose done pulse is still to come.
    logic [DEPTH_LOG2:0] credit;
    logic [DEPTH_LOG2:0] skip;

    // ------------------------------------------------------------------
    // Output register and error reporting
    // ------------------------------------------------------------------
    logic        out_valid;
    logic [95:0] out_dat;
    logic [15:0] drops;
    logic        ovf;

    // ------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------
    logic        trig_any;
    logic        trig_dead;
    logic        full;
    logic        push;
    logic        drop;
    logic        drop_live;
    logic        pop;
    logic [95:0] head;
    logic        head_dead;
    logic        head_ok;
    logic        load;
    logic        load_live;
    logic        done_skip;
    logic        done_credit;
    logic [95:0] new_rec;

    // A live trigger takes precedence over a dead one in the same cycle.
    // The dead trigger is then ignored and does not use an event number.
    assign trig_any  = trig_i | deadtrig_i;
    assign trig_dead = ~trig_i & deadtrig_i;

    // Full comes from the registered occupancy. A push in the same cycle as
    // a pop from a full store is therefore still rejected.
    assign full      = (count == DEPTH_CNT);
    assign push      = trig_any & ~full;
    assign drop      = trig_any & full;
    assign drop_live = drop & trig_i;

    // A consumer pop frees the slot of the record on the output register.
    assign pop       = out_valid & hdr_ready_i;

    // The oldest record not yet shown may move to the output register if it
    // is dead, or if it is live and a completed readout is available for it.
    // A live head without credit holds back everything behind it.
    assign head      = mem[rd_ptr];
    assign head_dead = head[95];
    assign head_ok   = (pend != '0) && (head_dead || (credit != '0));
    assign load      = head_ok && (!out_valid || hdr_ready_i);
    assign load_live = load & ~head_dead;

    // A done pulse first settles any dropped live trigger. Only after that
    // does it count as credit for a queued live record.
    assign done_skip   = trig_done_i & (skip != '0);
    assign done_credit = trig_done_i & (skip == '0);

    // The record uses the register values of the trigger cycle. A trigger
    // that coincides with pps_i therefore sees the pre-PPS counter values.
    assign new_rec = {trig_dead, pps_cnt, trig_info_i, subsec, evnum};

    // Sub-second, PPS and event-number counters.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            subsec  <= '0;
            pps_cnt <= '0;
            evnum   <= '0;
        end else begin
            subsec <= pps_i ? 32'd0 : subsec + 32'd1;
            if (pps_i) begin
                pps_cnt <= pps_cnt + 15'd1;
            end
            // Every accepted trigger uses an event number, including dropped
            // ones. Gaps in the event number therefore show where drops happened.
            if (trig_any) begin
                evnum <= evnum + 32'd1;
            end
        end
    end

    // Record storage. The array has no reset because occupancy is tracked
    // separately.
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    // Write/read pointers, total occupancy and not-yet-shown count.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pend   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({push, load})
                2'b10:   pend <= pend + 1'b1;
                2'b01:   pend <= pend - 1'b1;
                default: pend <= pend;
            endcase
        end
    end

    // Readout credit and skip counters. Both saturate.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            credit <= '0;
            skip   <= '0;
        end else begin
            case ({done_credit, load_live})
                2'b10:   credit <= (credit == CREDIT_MAX) ? credit : credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
            case ({drop_live, done_skip})
                2'b10:   skip <= (skip == SKIP_MAX) ? skip : skip + 1'b1;
                2'b01:   skip <= skip - 1'b1;
                default: skip <= skip;
            endcase
        end
    end

    // Registered first-word-fall-through output. A new record loads in the
    // same edge that pops the previous one, so the port can move one record
    // per cycle.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            out_valid <= 1'b0;
            out_dat   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_dat   <= head;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    // Drop counter (saturating) and sticky overflow flag.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            drops <= '0;
            ovf   <= 1'b0;
        end else if (drop) begin
            if (drops != 16'hFFFF) begin
                drops <= drops + 16'd1;
            end
            ovf <= 1'b1;
        end
    end

    assign hdr_valid_o  = out_valid;
    assign hdr_dat_o    = out_dat;
    assign hdr_full_o   = full;
    assign drop_count_o = drops;
    assign overflow_o   = ovf;

endmodule

// File: tb/tb_radiant_trig_header_builder.sv
// Testbench for radiant_trig_header_builder.
// A reference model built on a queue of records is stepped on every rising
// edge. A compare process checks the DUT outputs against the model at every
// falling edge. Directed scenarios pin the model to hand-computed literal
// values, and a randomized phase exercises everything else.

module tb_radiant_trig_header_builder;

    logic        clk;
    logic        rst_n;
    logic        pps;
    logic        trig;
    logic        dead;
    logic [15:0] info;
    logic        done;
    logic        ready;
    logic        hdr_valid;
    logic [95:0] hdr_dat;
    logic        hdr_full;
    logic [15:0] drop_count;
    logic        overflow;

    int vectors = 0;
    int errs    = 0;

    radiant_trig_header_builder #(.DEPTH_LOG2(4)) dut (
        .sys_clk_i    (clk),
        .rst_n_i      (rst_n),
        .pps_i        (pps),
        .trig_i       (trig),
        .deadtrig_i   (dead),
        .trig_info_i  (info),
        .trig_done_i  (done),
        .hdr_valid_o  (hdr_valid),
        .hdr_ready_i  (ready),
        .hdr_dat_o    (hdr_dat),
        .hdr_full_o   (hdr_full),
        .drop_count_o (drop_count),
        .overflow_o   (overflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [95:0] got, logic [95:0] want);
        vectors++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model. store_q holds every record still owned by the block,
    // oldest first. When m_valid is set, store_q[0] is the record on the
    // output port.
    // ------------------------------------------------------------------
    logic [95:0] store_q[$];
    logic [95:0] popped_q[$];
    int          m_credit;
    int          m_skip;
    bit          m_valid;
    logic [95:0] m_dat;
    logic [31:0] m_sub;
    logic [31:0] m_pps;
    logic [31:0] m_ev;
    int          m_drops;
    bit          m_ovf;
    bit          model_on = 0;

    always @(posedge clk) begin : model
        int          hidx;
        int          c;
        int          s;
        bit          full_now;
        bit          pop_now;
        bit          load_now;
        bit          head_live;
        logic [95:0] rec;
        logic [95:0] head_rec;
        if (!rst_n) begin
            store_q.delete();
            m_credit = 0;
            m_skip   = 0;
            m_valid  = 0;
            m_dat    = '0;
            m_sub    = 0;
            m_pps    = 0;
            m_ev     = 0;
            m_drops  = 0;
            m_ovf    = 0;
            model_on = 1;
        end else if (model_on) begin
            hidx      = m_valid ? 1 : 0;
            full_now  = (store_q.size() == 16);
            pop_now   = m_valid && ready;
            load_now  = 0;
            head_live = 0;
            head_rec  = '0;
            if (store_q.size() > hidx) begin
                head_rec  = store_q[hidx];
                head_live = !head_rec[95];
                load_now  = (!m_valid || ready) && (!head_live || m_credit > 0);
            end
            c = m_credit;
            s = m_skip;
            if (done) begin
                if (s > 0) s = s - 1;
                else       c = c + 1;
            end
            if (load_now && head_live) c = c - 1;
            if (c > 17) c = 17;
            if (trig || dead) begin
                rec  = {~trig, m_pps[14:0], info, m_sub, m_ev};
                m_ev = m_ev + 1;
                if (!full_now) begin
                    store_q.push_back(rec);
                end else begin
                    if (m_drops < 65535) m_drops = m_drops + 1;
                    m_ovf = 1;
                    if (trig) s = s + 1;
                end
            end
            if (s > 31) s = 31;
            m_credit = c;
            m_skip   = s;
            if (pop_now) void'(store_q.pop_front());
            if (load_now) begin
                m_valid = 1;
                m_dat   = head_rec;
            end else if (pop_now) begin
                m_valid = 0;
            end
            if (pps) begin
                m_sub = 0;
                m_pps = m_pps + 1;
            end else begin
                m_sub = m_sub + 1;
            end
        end
    end

    // Compare process and pop log (falling edge, away from the active edge)
    always @(negedge clk) begin
        if (model_on) begin
            check("hdr_valid", {95'd0, hdr_valid}, {95'd0, m_valid});
            check("hdr_full", {95'd0, hdr_full}, {95'd0, store_q.size() == 16});
            check("drop_count", {80'd0, drop_count}, 96'(m_drops));
            check("overflow", {95'd0, overflow}, {95'd0, m_ovf});
            if (m_valid) check("hdr_dat", hdr_dat, m_dat);
        end
        if (rst_n && hdr_valid === 1'b1 && ready) popped_q.push_back(hdr_dat);
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0, the first cycle after the reset edge.
    task automatic do_reset();
        rst_n = 1'b0;
        pps   = 1'b0;
        trig  = 1'b0;
        dead  = 1'b0;
        info  = '0;
        done  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        popped_q.delete();
    endtask

    task automatic pulse_dead(input logic [15:0] i);
        dead = 1'b1;
        info = i;
        step();
        dead = 1'b0;
        info = '0;
    endtask

    logic [95:0] want;
    bit          early_seen;

    initial begin
        rst_n = 1'b0;
        pps   = 1'b0;
        trig  = 1'b0;
        dead  = 1'b0;
        info  = '0;
        done  = 1'b0;
        ready = 1'b1;

        // Reset state and a single dead trigger
        do_reset();
        check("rst_valid", {95'd0, hdr_valid}, 96'd0);
        check("rst_dat", hdr_dat, 96'd0);
        check("rst_full", {95'd0, hdr_full}, 96'd0);
        check("rst_drop", {80'd0, drop_count}, 96'd0);
        check("rst_ovf", {95'd0, overflow}, 96'd0);
        repeat (100) step();
        pulse_dead(16'h00A5);
        check("dead_n1_valid", {95'd0, hdr_valid}, 96'd0);
        step();
        check("dead_n2_valid", {95'd0, hdr_valid}, 96'd1);
        want = {1'b1, 15'd0, 16'h00A5, 32'd100, 32'd0};
        check("dead_n2_dat", hdr_dat, want);
        step();
        check("dead_n3_valid", {95'd0, hdr_valid}, 96'd0);

        // Live trigger held until its done pulse
        do_reset();
        repeat (10) step();
        trig = 1'b1;
        info = 16'h1234;
        step();
        trig = 1'b0;
        info = '0;
        early_seen = 0;
        for (int cyc = 11; cyc <= 41; cyc++) begin
            done = (cyc == 40);
            if (hdr_valid === 1'b1) early_seen = 1;
            step();
        end
        done = 1'b0;
        check("live_not_early", {95'd0, early_seen}, 96'd0);
        check("live_c42_valid", {95'd0, hdr_valid}, 96'd1);
        check("live_dead_bit", {95'd0, hdr_dat[95]}, 96'd0);
        check("live_evnum", {64'd0, hdr_dat[31:0]}, 96'd0);
        check("live_subsec", {64'd0, hdr_dat[63:32]}, 96'd10);

        // Ordering: live, dead, dead, then done
        do_reset();
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        dead = 1'b1;
        step();
        step();
        dead = 1'b0;
        early_seen = 0;
        repeat (5) begin
            if (hdr_valid === 1'b1) early_seen = 1;
            step();
        end
        check("order_blocked", {95'd0, early_seen}, 96'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (6) step();
        check("order_count", 96'(popped_q.size()), 96'd3);
        for (int k = 0; k < 3; k++) begin
            if (popped_q.size() > k) begin
                check("order_ev", {64'd0, popped_q[k][31:0]}, 96'(k));
                check("order_dead", {95'd0, popped_q[k][95]}, {95'd0, k != 0});
            end
        end

        // PPS coincidence
        do_reset();
        repeat (50) step();
        pps  = 1'b1;
        dead = 1'b1;
        step();
        pps = 1'b0;
        step();
        dead = 1'b0;
        repeat (5) step();
        check("pps_count", 96'(popped_q.size()), 96'd2);
        if (popped_q.size() >= 2) begin
            check("pps0_subsec", {64'd0, popped_q[0][63:32]}, 96'd50);
            check("pps0_pps", {81'd0, popped_q[0][94:80]}, 96'd0);
            check("pps1_subsec", {64'd0, popped_q[1][63:32]}, 96'd0);
            check("pps1_pps", {81'd0, popped_q[1][94:80]}, 96'd1);
            check("pps1_ev", {64'd0, popped_q[1][31:0]}, 96'd1);
        end

        // Overflow: 18 dead triggers with the consumer stalled
        do_reset();
        ready = 1'b0;
        for (int k = 0; k < 18; k++) pulse_dead(16'(k));
        step();
        check("ovf_full", {95'd0, hdr_full}, 96'd1);
        check("ovf_drops", {80'd0, drop_count}, 96'd2);
        check("ovf_flag", {95'd0, overflow}, 96'd1);
        ready = 1'b1;
        repeat (20) step();
        check("ovf_drain_count", 96'(popped_q.size()), 96'd16);
        for (int k = 0; k < 16; k++) begin
            if (popped_q.size() > k) check("ovf_drain_ev", {64'd0, popped_q[k][31:0]}, 96'(k));
        end
        pulse_dead(16'h0BEE);
        repeat (4) step();
        if (popped_q.size() > 16) check("ovf_next_ev", {64'd0, popped_q[16][31:0]}, 96'd18);
        else check("ovf_next_present", 96'(popped_q.size()), 96'd17);

        // Dropped live trigger absorbs its done pulse, then reset mid-queue
        do_reset();
        ready = 1'b0;
        for (int k = 0; k < 16; k++) pulse_dead(16'(k));
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        check("skip_drop", {80'd0, drop_count}, 96'd1);
        ready = 1'b1;
        repeat (20) step();
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (10) step();
        check("skip_no_credit", {95'd0, hdr_valid}, 96'd0);
        ready = 1'b0;
        pulse_dead(16'h0001);
        pulse_dead(16'h0002);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid", {95'd0, hdr_valid}, 96'd0);
        check("mid_rst_dat", hdr_dat, 96'd0);
        check("mid_rst_full", {95'd0, hdr_full}, 96'd0);
        check("mid_rst_drop", {80'd0, drop_count}, 96'd0);
        check("mid_rst_ovf", {95'd0, overflow}, 96'd0);

        // Randomized traffic, with the consumer bias changing per chunk
        do_reset();
        for (int chunk = 0; chunk < 6; chunk++) begin
            int rdy_pct;
            rdy_pct = (chunk % 3 == 0) ? 20 : ((chunk % 3 == 1) ? 60 : 95);
            repeat (500) begin
                rst_n = ($urandom_range(0, 1499) != 0);
                trig  = ($urandom_range(0, 5) == 0);
                dead  = ($urandom_range(0, 5) == 0);
                done  = ($urandom_range(0, 7) == 0);
                pps   = ($urandom_range(0, 49) == 0);
                info  = 16'($urandom);
                ready = ($urandom_range(0, 99) < rdy_pct);
                step();
            end
        end
        rst_n = 1'b1;
        trig  = 1'b0;
        dead  = 1'b0;
        done  = 1'b0;
        pps   = 1'b0;
        ready = 1'b1;
        repeat (30) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
